// File: rtl/box_pkg.sv
// Shared screen geometry, colour constants, FSM encoding and size saturation for box_drawer.
package box_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int MAX_DIM  = 16;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;
  localparam logic [COLOUR_W-1:0] COL_RED   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Oversize requests draw a MAX_DIM box rather than being rejected.
  function automatic logic [4:0] sat_dim(input logic [4:0] d);
    return (d > 5'(MAX_DIM)) ? 5'(MAX_DIM) : d;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Two-level cx/cy offset counter in raster order; exposes the offset that follows the
// current one and flags the last pixel of the box. Load wins over step.
module raster_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [4:0] i_w,
  input  logic [4:0] i_h,
  output logic [4:0] o_nxt_cx,
  output logic [4:0] o_nxt_cy,
  output logic       o_last
);

  logic [4:0] r_cx;
  logic [4:0] r_cy;
  logic [4:0] r_w;
  logic [4:0] r_h;
  logic       w_row_end;

  always_comb begin
    w_row_end = (r_cx == (r_w - 5'd1));
    o_last    = w_row_end && (r_cy == (r_h - 5'd1));
    o_nxt_cx  = w_row_end ? 5'd0 : (r_cx + 5'd1);
    o_nxt_cy  = w_row_end ? (r_cy + 5'd1) : r_cy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx <= 5'd0;
      r_cy <= 5'd0;
      r_w  <= 5'd0;
      r_h  <= 5'd0;
    end else if (i_load) begin
      r_cx <= 5'd0;
      r_cy <= 5'd0;
      r_w  <= i_w;
      r_h  <= i_h;
    end else if (i_step) begin
      r_cx <= o_nxt_cx;
      r_cy <= o_nxt_cy;
    end
  end

endmodule

// File: rtl/box_drawer.sv
// Streams one box per req handshake to the VGA plot port, one pixel/clock, first pixel the cycle
// after accept; req_ready is low while busy. BOX_OUTLINE_EN adds req_outline (perimeter only).
module box_drawer
  import box_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_x,
  input  logic [6:0]          req_y,
  input  logic [4:0]          req_w,
  input  logic [4:0]          req_h,
  input  logic [COLOUR_W-1:0] req_colour,
`ifdef BOX_OUTLINE_EN
  input  logic                req_outline,
`endif
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                done
);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_plot;
  logic                  r_done;
  logic [7:0]            r_vga_x;
  logic [6:0]            r_vga_y;
  logic [COLOUR_W-1:0]   r_vga_colour;
  logic [7:0]            r_x0;
  logic [6:0]            r_y0;
  logic [COLOUR_W-1:0]   r_colour;

  logic                  w_accept;
  logic                  w_zero;
  logic                  w_draw;
  logic [4:0]            w_w_sat;
  logic [4:0]            w_h_sat;
  logic [4:0]            w_nxt_cx;
  logic [4:0]            w_nxt_cy;
  logic                  w_last;
  logic [4:0]            w_px_cx;
  logic [4:0]            w_px_cy;
  logic [7:0]            w_base_x;
  logic [6:0]            w_base_y;
  logic [8:0]            w_sum_x;
  logic [7:0]            w_sum_y;
  logic                  w_clip;
  logic                  w_plot;

  assign req_ready  = r_ready;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_plot;
  assign done       = r_done;

  raster_counter u_raster (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept),
    .i_step   (w_draw && !w_last),
    .i_w      (w_w_sat),
    .i_h      (w_h_sat),
    .o_nxt_cx (w_nxt_cx),
    .o_nxt_cy (w_nxt_cy),
    .o_last   (w_last)
  );

`ifdef BOX_OUTLINE_EN
  logic       r_outline;
  logic [4:0] r_w;
  logic [4:0] r_h;
  logic       w_ol;
  logic [4:0] w_dw;
  logic [4:0] w_dh;
  logic       w_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outline <= 1'b0;
      r_w       <= 5'd0;
      r_h       <= 5'd0;
    end else if (w_accept) begin
      r_outline <= req_outline;
      r_w       <= w_w_sat;
      r_h       <= w_h_sat;
    end
  end

  always_comb begin
    w_ol   = w_draw ? r_outline : req_outline;
    w_dw   = w_draw ? r_w : w_w_sat;
    w_dh   = w_draw ? r_h : w_h_sat;
    w_edge = (w_px_cx == 5'd0) || (w_px_cx == (w_dw - 5'd1)) ||
             (w_px_cy == 5'd0) || (w_px_cy == (w_dh - 5'd1));
  end
`endif

  // The pixel being registered this edge: offset (0,0) of the incoming request on accept,
  // otherwise the successor of the pixel currently on the outputs.
  always_comb begin
    w_accept = req_valid && r_ready;
    w_zero   = (req_w == 5'd0) || (req_h == 5'd0);
    w_draw   = (r_state == DRAW);
    w_w_sat  = sat_dim(req_w);
    w_h_sat  = sat_dim(req_h);
    w_px_cx  = w_draw ? w_nxt_cx : 5'd0;
    w_px_cy  = w_draw ? w_nxt_cy : 5'd0;
    w_base_x = w_draw ? r_x0 : req_x;
    w_base_y = w_draw ? r_y0 : req_y;
    w_sum_x  = {1'b0, w_base_x} + {4'b0, w_px_cx};
    w_sum_y  = {1'b0, w_base_y} + {3'b0, w_px_cy};
    w_clip   = (w_sum_x >= 9'(SCREEN_W)) || (w_sum_y >= 8'(SCREEN_H));
`ifdef BOX_OUTLINE_EN
    w_plot   = !w_clip && (!w_ol || w_edge);
`else
    w_plot   = !w_clip;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_plot       <= 1'b0;
      r_done       <= 1'b0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= COL_BLACK;
      r_x0         <= 8'd0;
      r_y0         <= 7'd0;
      r_colour     <= COL_BLACK;
    end else begin
      case (r_state)
        IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_ready  <= 1'b0;
            r_x0     <= req_x;
            r_y0     <= req_y;
            r_colour <= req_colour;
            if (w_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= DRAW;
              r_vga_x      <= w_sum_x[7:0];
              r_vga_y      <= w_sum_y[6:0];
              r_vga_colour <= req_colour;
              r_plot       <= w_plot;
            end
          end
        end
        DRAW: begin
          if (w_last) begin
            r_state <= DONE;
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vga_x      <= w_sum_x[7:0];
            r_vga_y      <= w_sum_y[6:0];
            r_vga_colour <= r_colour;
            r_plot       <= w_plot;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_plot  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Directed bench for box_drawer: outputs are sampled on the falling edge, cycle k = k-th cycle after accept.
module tb_box_drawer;
  import box_pkg::*;

  logic                clk;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [7:0]          req_x;
  logic [6:0]          req_y;
  logic [4:0]          req_w;
  logic [4:0]          req_h;
  logic [COLOUR_W-1:0] req_colour;
`ifdef BOX_OUTLINE_EN
  logic                req_outline;
`endif
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                done;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] rec_x [0:63];
  logic [6:0] rec_y [0:63];
  logic [2:0] rec_c [0:63];
  logic       rec_p [0:63];
  logic       rec_d [0:63];
  logic       rec_r [0:63];

  box_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
`ifdef BOX_OUTLINE_EN
    .req_outline(req_outline),
`endif
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents a request once req_ready is seen (bounded wait).
  task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic [4:0] w,
                       input logic [4:0] h, input logic [2:0] col);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_wait", 32'(req_ready), 32'd1);
    req_x      = x;
    req_y      = y;
    req_w      = w;
    req_h      = h;
    req_colour = col;
    req_valid  = 1'b1;
  endtask

  task automatic capture(input int n, input int drop_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_x[k] = vga_x;
      rec_y[k] = vga_y;
      rec_c[k] = vga_colour;
      rec_p[k] = vga_plot;
      rec_d[k] = done;
      rec_r[k] = req_ready;
      if (k == drop_at) req_valid = 1'b0;
    end
  endtask

  function automatic int cnt_plot(input int n);
    int c;
    c = 0;
    for (int k = 1; k <= n; k++) if (rec_p[k]) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int n);
    int c;
    c = 0;
    for (int k = 1; k <= n; k++) if (rec_d[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) if (rec_d[k]) return k;
    return 0;
  endfunction

  function automatic int cnt_ready(input int n);
    int c;
    c = 0;
    for (int k = 1; k <= n; k++) if (rec_r[k]) c++;
    return c;
  endfunction

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_x      = 8'd0;
    req_y      = 7'd0;
    req_w      = 5'd0;
    req_h      = 5'd0;
    req_colour = 3'd0;
`ifdef BOX_OUTLINE_EN
    req_outline = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_plot",  32'(vga_plot),  32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_x",     32'(vga_x),     32'd0);
    chk("rst_y",     32'(vga_y),     32'd0);
    chk("rst_col",   32'(vga_colour), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4x4 at (10,20): pixels in cycles 1..16, done at 17.
    issue(8'd10, 7'd20, 5'd4, 5'd4, COL_RED);
    capture(20, 1);
    chk("basic_done_cyc", 32'(first_done(20)), 32'd17);
    chk("basic_done_cnt", 32'(cnt_done(20)), 32'd1);
    chk("basic_plots", 32'(cnt_plot(20)), 32'd16);
    chk("basic_busy_rdy", 32'(cnt_ready(17)), 32'd0);
    chk("basic_rdy_after", 32'(rec_r[18]), 32'd1);
    chk("basic_col", 32'(rec_c[1]), 32'(COL_RED));
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("basic_x%0d", k), 32'(rec_x[k]), 32'(10 + (k - 1) % 4));
      chk($sformatf("basic_y%0d", k), 32'(rec_y[k]), 32'(20 + (k - 1) / 4));
      chk($sformatf("basic_p%0d", k), 32'(rec_p[k]), 32'd1);
    end

    // Right/bottom clipping at (157,118): only cx 0..2, cy 0..1 are visible.
    issue(8'd157, 7'd118, 5'd4, 5'd4, COL_WHITE);
    capture(20, 1);
    chk("clip_plots", 32'(cnt_plot(20)), 32'd6);
    chk("clip_done_cyc", 32'(first_done(20)), 32'd17);
    chk("clip_p3", 32'(rec_p[3]), 32'd1);
    chk("clip_p4", 32'(rec_p[4]), 32'd0);
    chk("clip_p7", 32'(rec_p[7]), 32'd1);
    chk("clip_p9", 32'(rec_p[9]), 32'd0);

    // Zero-size requests finish immediately with no plots.
    issue(8'd30, 7'd30, 5'd0, 5'd5, COL_RED);
    capture(4, 1);
    chk("zero_w_done", 32'(first_done(4)), 32'd1);
    chk("zero_w_plots", 32'(cnt_plot(4)), 32'd0);
    chk("zero_w_rdy2", 32'(rec_r[2]), 32'd1);
    issue(8'd30, 7'd30, 5'd5, 5'd0, COL_RED);
    capture(4, 1);
    chk("zero_h_done", 32'(first_done(4)), 32'd1);
    chk("zero_h_plots", 32'(cnt_plot(4)), 32'd0);

    // Oversize width saturates to 16.
    issue(8'd100, 7'd0, 5'd20, 5'd1, 3'd1);
    capture(20, 1);
    chk("over_plots", 32'(cnt_plot(20)), 32'd16);
    chk("over_done_cyc", 32'(first_done(20)), 32'd17);
    chk("over_last_x", 32'(rec_x[16]), 32'd115);

    // Back-to-back: valid stays high, B queued behind A (2x2).
    issue(8'd0, 7'd0, 5'd2, 5'd2, COL_WHITE);
    @(posedge clk);
    #1;
    req_x      = 8'd50;
    req_y      = 7'd60;
    req_w      = 5'd3;
    req_h      = 5'd2;
    req_colour = 3'd2;
    capture(18, 7);
    chk("b2b_doneA", 32'(rec_d[5]), 32'd1);
    chk("b2b_rdy5", 32'(rec_r[5]), 32'd0);
    chk("b2b_rdy6", 32'(rec_r[6]), 32'd1);
    chk("b2b_p6", 32'(rec_p[6]), 32'd0);
    chk("b2b_lastA_x", 32'(rec_x[4]), 32'd1);
    chk("b2b_lastA_y", 32'(rec_y[4]), 32'd1);
    chk("b2b_B_x", 32'(rec_x[7]), 32'd50);
    chk("b2b_B_y", 32'(rec_y[7]), 32'd60);
    chk("b2b_B_p", 32'(rec_p[7]), 32'd1);
    chk("b2b_B_col", 32'(rec_c[7]), 32'd2);
    chk("b2b_doneB", 32'(rec_d[13]), 32'd1);
    chk("b2b_done_cnt", 32'(cnt_done(18)), 32'd2);
    chk("b2b_plots", 32'(cnt_plot(18)), 32'd10);

    // Reset during the fifth pixel of a 4x4 draw.
    issue(8'd30, 7'd40, 5'd4, 5'd4, COL_RED);
    capture(5, 1);
    chk("rmid_x5", 32'(rec_x[5]), 32'd30);
    chk("rmid_y5", 32'(rec_y[5]), 32'd41);
    chk("rmid_p5", 32'(rec_p[5]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_plot", 32'(vga_plot), 32'd0);
    chk("rmid_ready", 32'(req_ready), 32'd1);
    chk("rmid_done", 32'(done), 32'd0);
    reset = 1'b0;
    capture(6, 0);
    chk("rmid_no_done", 32'(cnt_done(6)), 32'd0);
    chk("rmid_no_plot", 32'(cnt_plot(6)), 32'd0);
    issue(8'd5, 7'd5, 5'd2, 5'd1, COL_WHITE);
    capture(4, 1);
    chk("rmid_fresh_done", 32'(first_done(4)), 32'd3);
    chk("rmid_fresh_plots", 32'(cnt_plot(4)), 32'd2);
    chk("rmid_fresh_x2", 32'(rec_x[2]), 32'd6);

`ifdef BOX_OUTLINE_EN
    // Outline 4x4: interior offsets (1..2,1..2) are cycles 6,7,10,11.
    req_outline = 1'b1;
    issue(8'd20, 7'd30, 5'd4, 5'd4, COL_RED);
    capture(20, 1);
    req_outline = 1'b0;
    chk("ol_plots", 32'(cnt_plot(20)), 32'd12);
    chk("ol_done_cyc", 32'(first_done(20)), 32'd17);
    chk("ol_p5", 32'(rec_p[5]), 32'd1);
    chk("ol_p6", 32'(rec_p[6]), 32'd0);
    chk("ol_p7", 32'(rec_p[7]), 32'd0);
    chk("ol_p10", 32'(rec_p[10]), 32'd0);
    chk("ol_p11", 32'(rec_p[11]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
